// File: rtl/uart_rx_sampler.sv
// 8N1 UART receive front-end: rx synchroniser, mid-bit sampler FSM and a valid/ready
// holding register with framing-error and overrun pulses.
module uart_rx_sampler #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned FlushW = $clog2(SYNC_STAGES + 1);

    localparam logic [CntW-1:0]   HalfLoad  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0]   FullLoad  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(DATA_BITS - 1);
    localparam logic [FlushW-1:0] FlushDone = FlushW'(SYNC_STAGES);

    typedef enum logic [2:0] {StWaitIdle, StIdle, StStart, StData, StStop} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [FlushW-1:0]      flush_q, flush_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   rx_s, sample, byte_done;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign sample = (cnt_q == '0);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StWaitIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The synchroniser resets to ones, which says nothing about the real line, so leaving
    // WAIT_IDLE also waits until the chain has been refilled from the pin.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitIdle: if (rx_s && (flush_q == FlushDone)) state_d = StIdle;
            StIdle:     if (!rx_s) state_d = StStart;
            StStart:    if (sample) state_d = rx_s ? StIdle : StData;
            StData:     if (sample && (idx_q == LastIdx)) state_d = StStop;
            StStop:     if (sample) state_d = rx_s ? StIdle : StWaitIdle;
            default:    state_d = StWaitIdle;
        endcase
    end

    always_comb begin
        cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
        flush_d     = (flush_q == FlushDone) ? flush_q : flush_q + 1'b1;
        case (state_q)
            StIdle: if (!rx_s) cnt_d = HalfLoad;
            StStart: begin
                if (sample && !rx_s) begin
                    cnt_d = FullLoad;
                    idx_d = '0;
                end
            end
            StData: begin
                if (sample) begin
                    shreg_d = DATA_BITS'({rx_s, shreg_q} >> 1);
                    cnt_d   = FullLoad;
                    idx_d   = idx_q + 1'b1;
                end
            end
            StStop: begin
                if (sample) begin
                    byte_done   = rx_s;
                    frame_err_d = !rx_s;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == StStart) || (state_d == StData) || (state_d == StStop);

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (byte_done) begin
            // A same-cycle consume frees the slot, so the new byte is taken without overrun
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            flush_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_i};
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            flush_q     <= flush_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule
